// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the general-purpose register file.
// Optional macro: REGFILE_BYPASS_EN (write-through forwarding on the read ports).
package regfile_pkg;

  localparam int unsigned REG_W      = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_W-1:0]      ZERO_WORD     = '0;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO      = '0;
  localparam logic                  READ_ENABLE   = 1'b1;
  localparam logic                  READ_DISABLE  = 1'b0;
  localparam logic                  WRITE_ENABLE  = 1'b1;
  localparam logic                  WRITE_DISABLE = 1'b0;
  localparam logic                  RST_N_ENABLE  = 1'b0;

  typedef enum logic {
    REGFILE_CLEAR = 1'b0,
    REGFILE_READY = 1'b1
  } regfile_state_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// Post-reset clear sequencer: walks entries 1..2**ADDR_W-1 writing zero, then
// reports READY. init_busy is registered straight from the FSM.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              init_busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);

  regfile_state_e    r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_busy;

  always_ff @(posedge clk) begin
    if (rst == RST_N_ENABLE) begin
      r_state <= REGFILE_CLEAR;
      r_ptr   <= FIRST_ADDR;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        REGFILE_CLEAR: begin
          r_ptr <= r_ptr + ADDR_W'(1);
          // Last entry is written on this edge; leave CLEAR with it.
          if (r_ptr == LAST_ADDR) begin
            r_state <= REGFILE_READY;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= REGFILE_READY;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we    = r_busy;
  assign clr_addr  = r_ptr;
  assign init_busy = r_busy;

endmodule

// File: rtl/regfile.sv
// Two-read / one-write register file with hardwired $zero and a post-reset clear.
// Optional macro: REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REG_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              init_busy
);

  localparam int unsigned N_STORED = (1 << ADDR_W) - 1;

  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_busy;
  logic              w_run;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [ADDR_W-1:0] w_widx;
  logic [ADDR_W-1:0] w_ridx1;
  logic [ADDR_W-1:0] w_ridx2;
  logic              w_rd_ok1;
  logic              w_rd_ok2;

  // Entry 0 is never stored: slot k holds register k+1.
  logic [DATA_W-1:0] r_mem [0:N_STORED-1];

  regfile_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_we    (w_clr_we),
    .clr_addr  (w_clr_addr),
    .init_busy (w_busy)
  );

  assign init_busy = w_busy;
  assign w_run     = (rst != RST_N_ENABLE);

  // While clearing, the sequencer owns the write port and write-back is dropped.
  assign w_wr_en   = w_run && (w_clr_we || ((we == WRITE_ENABLE) && (waddr != '0)));
  assign w_wr_addr = w_clr_we ? w_clr_addr : waddr;
  assign w_wr_data = w_clr_we ? '0 : wdata;
  assign w_widx    = w_wr_addr - ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_widx] <= w_wr_data;
    end
  end

  assign w_ridx1  = raddr1 - ADDR_W'(1);
  assign w_ridx2  = raddr2 - ADDR_W'(1);
  assign w_rd_ok1 = w_run && !w_busy && (re1 == READ_ENABLE) && (raddr1 != '0);
  assign w_rd_ok2 = w_run && !w_busy && (re2 == READ_ENABLE) && (raddr2 != '0);

  always_comb begin
    rdata1 = '0;
    if (w_rd_ok1) begin
      rdata1 = r_mem[w_ridx1];
`ifdef REGFILE_BYPASS_EN
      if ((we == WRITE_ENABLE) && (waddr == raddr1)) rdata1 = wdata;
`endif
    end
  end

  always_comb begin
    rdata2 = '0;
    if (w_rd_ok2) begin
      rdata2 = r_mem[w_ridx2];
`ifdef REGFILE_BYPASS_EN
      if ((we == WRITE_ENABLE) && (waddr == raddr2)) rdata2 = wdata;
`endif
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: per-cycle reference model plus directed literal checks.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        init_busy;

  int n_tests = 0;
  int n_fail  = 0;

  regfile dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .re1       (re1),
    .raddr1    (raddr1),
    .rdata1    (rdata1),
    .re2       (re2),
    .raddr2    (raddr2),
    .rdata2    (rdata2),
    .init_busy (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents, and how many clear cycles have elapsed.
  logic [31:0] m_regs [32];
  bit          m_valid = 1'b0;
  bit          m_busy  = 1'b1;
  int          m_clr_cycles = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_valid      = 1'b1;
      m_busy       = 1'b1;
      m_clr_cycles = 0;
    end else if (m_busy) begin
      m_clr_cycles++;
      if (m_clr_cycles == 31) begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_busy = 1'b0;
      end
    end else if (we && waddr != 5'd0) begin
      m_regs[waddr] = wdata;
    end
  end

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] ra);
    if (!rst || m_busy || !re || ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && waddr == ra) return wdata;
`endif
    return m_regs[ra];
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_busy", {31'b0, init_busy}, {31'b0, m_busy});
      chk("model_rd1", rdata1, exp_rd(re1, raddr1));
      chk("model_rd2", rdata2, exp_rd(re2, raddr2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts busy cycles after release; drops the CLEAR-time write attempt once READY.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (init_busy) n++;
      else we = 1'b0;
    end
  endtask

  initial begin
    int nb;
    logic [31:0] exp9;
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b0; raddr2 = '0;

    repeat (3) step();
    @(negedge clk);
    chk("rst_busy", {31'b0, init_busy}, 32'd1);
    chk("rst_rd1", rdata1, 32'h0);

    // Release reset with a write-back to r3 pending throughout CLEAR.
    step();
    rst = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'hFF;
    count_busy(nb);
    chk("clear_len", nb, 32'd31);

    step();
    we = 1'b0;
    for (int i = 1; i < 32; i++) begin
      re1 = 1'b1; raddr1 = 5'(i); re2 = 1'b1; raddr2 = 5'(32 - i);
      @(negedge clk);
      chk("clr_rd1", rdata1, 32'h0);
      chk("clr_rd2", rdata2, 32'h0);
      step();
    end

    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; re1 = 1'b0; re2 = 1'b0;
    step();
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd5;
    @(negedge clk);
    chk("r5_read", rdata1, 32'hDEADBEEF);
    step();
    re1 = 1'b0;
    @(negedge clk);
    chk("r5_re_off", rdata1, 32'h0);

    step();
    we = 1'b1; waddr = 5'd0; wdata = 32'h12345678;
    step();
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
    @(negedge clk);
    chk("r0_rd1", rdata1, 32'h0);
    chk("r0_rd2", rdata2, 32'h0);

    step();
    we = 1'b1; waddr = 5'd9; wdata = 32'h1; re1 = 1'b0; re2 = 1'b0;
    step();
    we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5; re2 = 1'b1; raddr2 = 5'd9;
    re1 = 1'b1; raddr1 = 5'd5;
`ifdef REGFILE_BYPASS_EN
    exp9 = 32'hA5A5A5A5;
`else
    exp9 = 32'h1;
`endif
    @(negedge clk);
    chk("r9_same_cycle", rdata2, exp9);
    chk("r5_other_port", rdata1, 32'hDEADBEEF);
    step();
    we = 1'b0;
    @(negedge clk);
    chk("r9_next_cycle", rdata2, 32'hA5A5A5A5);

    step();
    we = 1'b1; waddr = 5'd7; wdata = 32'h77; re2 = 1'b0;
    step();
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd7;
    @(negedge clk);
    chk("r7_read", rdata1, 32'h77);

    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rd1", rdata1, 32'h0);
    step();
    rst = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'hFF;
    count_busy(nb);
    chk("reclear_len", nb, 32'd31);

    step();
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd3;
    @(negedge clk);
    chk("r7_after_rst", rdata1, 32'h0);
    chk("r3_clear_wr", rdata2, 32'h0);
    step();
    raddr1 = 5'd5; raddr2 = 5'd9;
    @(negedge clk);
    chk("r5_after_rst", rdata1, 32'h0);
    chk("r9_after_rst", rdata2, 32'h0);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile.md
# regfile

General-purpose register file answering the decode stage's two read ports and accepting the write-back stage's single write port. It holds 31 writable registers plus a hardwired $zero. A post-reset clear sequencer zeroes every entry, so register contents are always known. The decode stage consumes read data combinationally in the same cycle it presents the read enable and address. The pipeline stall logic holds instruction fetch while `init_busy` is high.

## Interface
- `DATA_W`, 32: register width; matches `` `Reg ``.
- `ADDR_W`, 5: register address width; matches `` `Reg_Addr ``. Entry count is 2**ADDR_W.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `we`  in  1  write enable from write-back.
- `waddr`  in  ADDR_W  write address.
- `wdata`  in  DATA_W  write data.
- `re1`  in  1  read enable, port 1 (rs).
- `raddr1`  in  ADDR_W  read address, port 1.
- `rdata1`  out  DATA_W  read data, port 1.
- `re2`  in  1  read enable, port 2 (rt).
- `raddr2`  in  ADDR_W  read address, port 2.
- `rdata2`  out  DATA_W  read data, port 2.
- `init_busy`  out  1  clear sequence in progress.

## Operation
- Two-state machine: CLEAR and READY.
- While `rst`=0: next state is CLEAR, clear pointer `ptr`=1, `init_busy`=1, `rdata1`=`rdata2`=0. Storage is not written during reset.
- CLEAR, with `rst`=1: each cycle, write 0 to mem[ptr] and increment `ptr`.
  - When the write to entry 2**ADDR_W-1 completes, move to READY.
  - Write port is ignored; `we` is dropped without any effect.
  - Both read ports return 0.
- READY:
  - On a rising edge with `we`=1 and `waddr`≠0, write `wdata` to mem[waddr].
  - A write to address 0 is discarded.
- Read port n (combinational), first matching rule applies:
  - `rst`=0, CLEAR, `ren`=0, or `raddrn`=0: return 0.
  - Otherwise, bypass condition (see Configuration): return `wdata`.
  - Otherwise: return mem[raddrn].
- Entry 0 is never stored. The storage array holds entries 1..2**ADDR_W-1 only.
- Both ports may read the same address; each resolves independently.

## Timing
- Read latency: 0 cycles (combinational from `ren`/`raddrn` to `rdatan`).
- Write latency: 1 edge. Data is visible to a non-bypassed read in the following cycle.
- Clear duration: exactly 2**ADDR_W-1 cycles (31 at default) after the first edge with `rst`=1.
  - `init_busy` falls on the edge that completes the last clear write.
  - The first valid write is accepted on the next edge after `init_busy` falls.
- Reset mid-clear or mid-operation: the next edge with `rst`=0 returns the block to CLEAR with `ptr`=1. The full clear sequence then reruns.
- Outputs are registered only in the FSM: `init_busy` comes from state. Read data has no registered path.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - In READY, when `we`=1, `waddr`=`raddrn`≠0, and `ren`=1, `rdatan` returns `wdata` in the same cycle.
  - This is write-through forwarding from write-back to decode.
- Not defined:
  - A same-cycle read of the address being written returns the old mem value.
  - The new value is returned from the next cycle.
  - Hazard handling moves to external forwarding.

## Structure
- Shared `define.v` supplies:
  - `` `Reg ``, `` `Reg_Addr ``, `` `Zero_Word ``, `` `Reg_Zero ``.
  - `` `Read_Enable ``/`` `Read_Disable ``, `` `Write_Enable ``/`` `Write_Disable ``.
  - New constants: `` `Rst_N_Enable `` (1'b0) and `` `Regfile_Clear ``/`` `Regfile_Ready `` state encodings.
- Sub-module `regfile_clr_seq` contains the FSM and pointer. It outputs `clr_we`, `clr_addr` and `init_busy`; the top muxes these onto the storage write port.

## Test plan
- Reset held low 3 cycles, then released: `init_busy`=1 for exactly 31 cycles after release, then 0. Reading r1..r31 then returns 0x00000000.
- READY, write r5=0xDEADBEEF; next cycle `re1`=1, `raddr1`=5 → `rdata1`=0xDEADBEEF. With `re1`=0 → 0.
- Write r0=0x12345678; then read r0 on both ports → 0x00000000.
- Same cycle: `we`=1, `waddr`=9, `wdata`=0xA5A5A5A5, `re2`=1, `raddr2`=9, r9 previously 0x1:
  - With `REGFILE_BYPASS_EN`: `rdata2`=0xA5A5A5A5.
  - Without it: `rdata2`=0x1, then 0xA5A5A5A5 the next cycle.
- `we`=1 to r3=0xFF during CLEAR → ignored; r3 reads 0 after `init_busy` falls.
- Fill r7=0x77, assert `rst`=0 for 1 cycle mid-operation:
  - `rdata1`=0 during reset.
  - `init_busy` reasserts for 31 cycles.
  - r7 reads 0 afterwards.
